conv_out_collector: RTL and testbench

// - Sink for the raw output stream of the DSP-cascade convolution PE (48-bit P, one sample/clk while valid).
// - Raster stream covers every FM column, so row-wrap samples are invalid; block keeps only valid window positions.
// - Requantizes kept results (arithmetic shift, optional ReLU, saturate), buffers them in a FIFO, emits valid/ready.
// - Signals frame completion and FIFO overflow (PE has no backpressure).

---
 rtl/conv_out_collector_if.sv | 14 +
 rtl/conv_out_collector.sv | 126 ++++++++++++
 tb/tb_conv_out_collector.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/conv_out_collector_if.sv
// Stream bundle between the convolution PE, the output collector and its consumer.
// The PE result side (i_valid, i_P) and the requantized output side (o_data, o_valid, i_ready).
interface conv_out_collector_if #(
  parameter int OUT_W = 16
);
  logic                    i_valid;
  logic signed [47:0]      i_P;
  logic signed [OUT_W-1:0] o_data;
  logic                    o_valid;
  logic                    i_ready;

  modport master (output i_valid, i_P, i_ready, input o_data, o_valid);
  modport slave  (input i_valid, i_P, i_ready, output o_data, o_valid);
endinterface

// File: rtl/conv_out_collector.sv
// Collects valid window positions from the PE raster stream, requantizes them and
// buffers them in a first-word-fall-through FIFO with frame-done and overflow flags.
module conv_out_collector #(
  parameter int KERNEL_SIZE = 3,
  parameter int FM_SIZE     = 5,
  parameter int SHIFT       = 8,
  parameter int OUT_W       = 16,
  parameter int RELU        = 0,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  conv_out_collector_if.slave  bus,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_overflow
);
  localparam int CW = (FM_SIZE > 1) ? $clog2(FM_SIZE) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] LAST_C  = CW'(FM_SIZE - KERNEL_SIZE);
  localparam logic [CW-1:0] COL_MAX = CW'(FM_SIZE - 1);
  localparam logic signed [47:0] MAX_V = {{(48-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [47:0] MIN_V = {{(48-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
  localparam logic signed [OUT_W-1:0] MAX_O = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic signed [OUT_W-1:0] MIN_O = {1'b1, {(OUT_W-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH} state_t;

  state_t                  state;
  logic [CW-1:0]           row, col;
  logic                    take, keep, last;
  logic signed [47:0]      shifted;
  logic signed [OUT_W-1:0] sat;
  logic                    rq_valid;
  logic signed [OUT_W-1:0] rq_data;
  logic [OUT_W-1:0]        mem [FIFO_DEPTH];
  logic [AW:0]             wr_ptr, rd_ptr;
  logic                    empty, full, do_read, do_write;

  // row/col stay at 0 while idle, so the first sample of a frame is (0,0).
  assign take = bus.i_valid && (state != S_FLUSH);
  assign keep = take && (col <= LAST_C);
  assign last = take && (row == LAST_C) && (col == LAST_C);
  assign o_busy = (state != S_IDLE);

  always_comb begin
    shifted = bus.i_P >>> SHIFT;
    if (RELU != 0 && shifted < 0) shifted = '0;
    if (shifted > MAX_V)      sat = MAX_O;
    else if (shifted < MIN_V) sat = MIN_O;
    else                      sat = shifted[OUT_W-1:0];
  end

  // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state  <= S_IDLE;
      row    <= '0;
      col    <= '0;
      o_done <= 1'b0;
    end else begin
      o_done <= 1'b0;
      unique case (state)
        S_IDLE, S_RUN: begin
          if (take) begin
            if (last) begin
              state <= S_FLUSH;
              row   <= '0;
              col   <= '0;
            end else begin
              state <= S_RUN;
              if (col == COL_MAX) begin
                col <= '0;
                row <= row + 1'b1;
              end else begin
                col <= col + 1'b1;
              end
            end
          end
        end
        S_FLUSH: begin
          if (!rq_valid && empty) begin
            o_done <= 1'b1;
            state  <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rq_valid <= 1'b0;
      rq_data  <= '0;
    end else begin
      rq_valid <= keep;
      rq_data  <= sat;
    end
  end

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_read  = !empty && bus.i_ready;
  assign do_write = rq_valid && (!full || do_read);

  // NOTE: FIFO storage is not reset; the pointers alone define which entries are live.
  always_ff @(posedge i_clk) begin
    if (do_write) mem[wr_ptr[AW-1:0]] <= rq_data;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      o_overflow <= 1'b0;
    end else begin
      if (do_write) wr_ptr <= wr_ptr + 1'b1;
      if (do_read)  rd_ptr <= rd_ptr + 1'b1;
      if (rq_valid && full && !do_read) o_overflow <= 1'b1;
    end
  end

  assign bus.o_valid = !empty;
  assign bus.o_data  = empty ? '0 : mem[rd_ptr[AW-1:0]];
endmodule

// File: tb/tb_conv_out_collector.sv
// Directed bench for conv_out_collector: raster keep rule, latency, gaps, reset,
// backpressure/overflow (4-deep FIFO) and a vector table for shift/ReLU/saturation.
module tb_conv_out_collector;
  logic i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  logic i_rst;
  logic busy_a, done_a_o, ovf_a;
  logic busy_b, done_b_o, ovf_b;
  logic busy_s, done_s_o, ovf_s;
  logic busy_r, done_r_o, ovf_r;

  conv_out_collector_if #(.OUT_W(16)) ifa (), ifb (), ifs (), ifr ();

  conv_out_collector #(.KERNEL_SIZE(2), .FM_SIZE(4), .SHIFT(0), .OUT_W(16), .RELU(0), .FIFO_DEPTH(16))
    u_a (.i_clk(i_clk), .i_rst(i_rst), .bus(ifa), .o_busy(busy_a), .o_done(done_a_o), .o_overflow(ovf_a));
  conv_out_collector #(.KERNEL_SIZE(2), .FM_SIZE(4), .SHIFT(0), .OUT_W(16), .RELU(0), .FIFO_DEPTH(4))
    u_b (.i_clk(i_clk), .i_rst(i_rst), .bus(ifb), .o_busy(busy_b), .o_done(done_b_o), .o_overflow(ovf_b));
  conv_out_collector #(.KERNEL_SIZE(1), .FM_SIZE(1), .SHIFT(8), .OUT_W(16), .RELU(0), .FIFO_DEPTH(2))
    u_s (.i_clk(i_clk), .i_rst(i_rst), .bus(ifs), .o_busy(busy_s), .o_done(done_s_o), .o_overflow(ovf_s));
  conv_out_collector #(.KERNEL_SIZE(1), .FM_SIZE(1), .SHIFT(0), .OUT_W(16), .RELU(1), .FIFO_DEPTH(2))
    u_r (.i_clk(i_clk), .i_rst(i_rst), .bus(ifr), .o_busy(busy_r), .o_done(done_r_o), .o_overflow(ovf_r));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Transfer monitors: a word moves on the next rising edge when o_valid && i_ready.
  int qa[$];
  int qb[$];
  int done_a = 0, done_b = 0, qa_at_done = 0, qb_at_done = 0;
  always @(negedge i_clk) begin
    if (ifa.o_valid && ifa.i_ready) qa.push_back(int'(ifa.o_data));
    if (ifb.o_valid && ifb.i_ready) qb.push_back(int'(ifb.o_data));
    if (done_a_o) begin done_a++; qa_at_done = qa.size(); end
    if (done_b_o) begin done_b++; qb_at_done = qb.size(); end
  end

  // Reference: 4x4 map, K=2 -> 11-sample frame, keep columns 0..2.
  int exp_q[$];
  task automatic build_expected(input int max_out);
    exp_q.delete();
    for (int i = 0; i < 11; i++)
      if ((i % 4) <= 2 && exp_q.size() < max_out) exp_q.push_back(i);
  endtask

  task automatic wait_done_a(input int budget);
    int k = 0;
    while (done_a == 0 && k < budget) begin @(negedge i_clk); k++; end
    check("a_done_seen", done_a > 0, 1);
    repeat (4) @(negedge i_clk);
  endtask

  task automatic run_frame_a(input string tag, input int gap);
    qa.delete();
    done_a = 0;
    ifa.i_ready = 1'b1;
    for (int i = 0; i < 11; i++) begin
      @(posedge i_clk); #1;
      ifa.i_valid = 1'b1;
      ifa.i_P     = 48'(i);
      @(negedge i_clk);
      if (gap == 0 && i == 0) check({tag, "_busy_first"}, busy_a, 0);
      if (gap == 0 && i == 1) check({tag, "_valid_n1"}, ifa.o_valid, 0);
      if (gap == 0 && i == 2) check({tag, "_valid_n2"}, ifa.o_valid, 1);
      if (gap == 0 && i == 2) check({tag, "_busy_run"}, busy_a, 1);
      if (gap != 0) begin
        @(posedge i_clk); #1;
        ifa.i_valid = 1'b0;
        ifa.i_P     = 48'sd999;
      end
    end
    @(posedge i_clk); #1;
    ifa.i_valid = 1'b0;
    wait_done_a(60);
    build_expected(9);
    check({tag, "_count"}, qa.size(), exp_q.size());
    for (int j = 0; j < exp_q.size() && j < qa.size(); j++)
      check($sformatf("%s_data%0d", tag, j), qa[j], exp_q[j]);
    check({tag, "_done_once"}, done_a, 1);
    check({tag, "_done_after_last"}, qa_at_done, 9);
    check({tag, "_busy_end"}, busy_a, 0);
  endtask

  typedef struct {
    bit                 sel;   // 0: saturating instance (SHIFT=8), 1: ReLU instance (SHIFT=0)
    logic signed [47:0] p;
    logic signed [15:0] exp_data;
  } vec_t;

  task automatic apply_vec(input vec_t v, input int idx);
    int   k;
    logic seen;
    @(posedge i_clk); #1;
    if (v.sel) begin ifr.i_valid = 1'b1; ifr.i_P = v.p; end
    else       begin ifs.i_valid = 1'b1; ifs.i_P = v.p; end
    @(posedge i_clk); #1;
    ifr.i_valid = 1'b0;
    ifs.i_valid = 1'b0;
    k = 0; seen = 1'b0;
    while (!seen && k < 10) begin
      @(negedge i_clk);
      seen = v.sel ? ifr.o_valid : ifs.o_valid;
      k++;
    end
    check($sformatf("vec%0d_valid", idx), seen, 1);
    check($sformatf("vec%0d_data", idx), v.sel ? ifr.o_data : ifs.o_data, v.exp_data);
    k = 0; seen = 1'b0;
    while (!seen && k < 10) begin
      @(negedge i_clk);
      seen = v.sel ? done_r_o : done_s_o;
      k++;
    end
    check($sformatf("vec%0d_done", idx), seen, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[12];
    vecs[0]  = '{1'b0, 48'sh0000_7FFF_FFFF, 16'sd32767};
    vecs[1]  = '{1'b0, -(48'sd1 <<< 40),    -16'sd32768};
    vecs[2]  = '{1'b0, 48'sh0000_0000_1234, 16'sh0012};
    vecs[3]  = '{1'b0, -48'sd256,           -16'sd1};
    vecs[4]  = '{1'b0, -48'sd1,             -16'sd1};
    vecs[5]  = '{1'b0, 48'sh0000_007F_FF00, 16'sd32767};
    vecs[6]  = '{1'b0, 48'sh0000_0080_0000, 16'sd32767};
    vecs[7]  = '{1'b0, -48'sh80_0000,       -16'sd32768};
    vecs[8]  = '{1'b0, -48'sh80_0100,       -16'sd32768};
    vecs[9]  = '{1'b1, -48'sd5,             16'sd0};
    vecs[10] = '{1'b1, 48'sd7,              16'sd7};
    vecs[11] = '{1'b1, 48'sh8000,           16'sd32767};

    i_rst = 1'b1;
    ifa.i_valid = 1'b0; ifa.i_P = '0; ifa.i_ready = 1'b1;
    ifb.i_valid = 1'b0; ifb.i_P = '0; ifb.i_ready = 1'b0;
    ifs.i_valid = 1'b0; ifs.i_P = '0; ifs.i_ready = 1'b1;
    ifr.i_valid = 1'b0; ifr.i_P = '0; ifr.i_ready = 1'b1;
    repeat (3) @(posedge i_clk);
    #1 i_rst = 1'b0;
    @(negedge i_clk);
    check("rst_valid", ifa.o_valid, 0);
    check("rst_data", ifa.o_data, 0);
    check("rst_busy", busy_a, 0);
    check("rst_done", done_a_o, 0);
    check("rst_overflow", ovf_a, 0);

    run_frame_a("contig", 0);
    run_frame_a("gaps", 1);

    // Reset in the middle of a frame with data parked in the FIFO.
    ifa.i_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge i_clk); #1;
      ifa.i_valid = 1'b1;
      ifa.i_P     = 48'(i);
    end
    @(posedge i_clk); #1;
    ifa.i_valid = 1'b0;
    repeat (2) @(negedge i_clk);
    check("mid_valid_before_rst", ifa.o_valid, 1);
    @(posedge i_clk); #1 i_rst = 1'b1;
    @(posedge i_clk); #1 i_rst = 1'b0;
    @(negedge i_clk);
    check("mid_rst_valid", ifa.o_valid, 0);
    check("mid_rst_busy", busy_a, 0);
    check("mid_rst_data", ifa.o_data, 0);
    run_frame_a("after_rst", 0);

    // Backpressure into a 4-deep FIFO: first four kept values survive, the rest drop.
    qb.delete();
    done_b = 0;
    ifb.i_ready = 1'b0;
    for (int i = 0; i < 11; i++) begin
      @(posedge i_clk); #1;
      ifb.i_valid = 1'b1;
      ifb.i_P     = 48'(i);
      @(negedge i_clk);
      if (i == 5) check("bp_overflow_not_yet", ovf_b, 0);
    end
    @(posedge i_clk); #1;
    ifb.i_valid = 1'b0;
    repeat (4) @(negedge i_clk);
    check("bp_overflow", ovf_b, 1);
    check("bp_valid_held", ifb.o_valid, 1);
    check("bp_head_stable", ifb.o_data, 0);
    check("bp_busy_flush", busy_b, 1);
    check("bp_no_done_yet", done_b, 0);
    @(posedge i_clk); #1;
    ifb.i_ready = 1'b1;
    begin
      int k = 0;
      while (done_b == 0 && k < 40) begin @(negedge i_clk); k++; end
    end
    repeat (3) @(negedge i_clk);
    build_expected(4);
    check("bp_count", qb.size(), exp_q.size());
    for (int j = 0; j < exp_q.size() && j < qb.size(); j++)
      check($sformatf("bp_data%0d", j), qb[j], exp_q[j]);
    check("bp_done_once", done_b, 1);
    check("bp_done_after_last", qb_at_done, 4);
    check("bp_overflow_sticky", ovf_b, 1);

    // K==F single-sample frames through the requantizer.
    for (int i = 0; i < 12; i++) apply_vec(vecs[i], i);
    check("sat_no_overflow", ovf_s, 0);
    check("relu_no_overflow", ovf_r, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
